cia_timer_ctrl_n: RTL and testbench
===================================

# cia_timer_ctrl_n

Parametrised timer control block for the CIA core: holds NCH control registers (CRA, CRB, …) and derives per-channel start/toggle/force-load/count strobes for NCH cascadable interval timers. It generalises the two-channel timer control to an arbitrary channel count with an arbitrary cascade chain, and detects CNT edges internally. It sits between the register bus decode and the timer datapath instances, with all state advancing on the PHI2 falling-edge strobe.

## Interface
Parameters:
- NCH, 2: number of timer channels (1..8).
- ADDR_BASE, 4'hE: register address of channel 0; channel i sits at ADDR_BASE+i (mod 16).

Ports:
- clk  in  1  system clock; the block has one clock.
- res_n  in  1  reset, asynchronous, active-low.
- phi2_dn  in  1  single-clk strobe marking the PHI2 falling edge; all state advances only on it.
- we  in  1  register write enable (qualified by phi2_dn).
- addr  in  4  register address.
- data  in  8  write data.
- cnt  in  1  CNT pin level, already synchronised to clk.
- ufl  in  NCH  timer underflow, one bit per channel, valid in the phi2_dn cycle.
- regs  out  NCH*8  readback; channel i in bits [8i+7:8i].
- start  out  NCH  timer running.
- toggle  out  NCH  PB output mode: 1 = toggle, 0 = pulse.
- force_load  out  NCH  load latch into counter.
- count  out  NCH  decrement enable for the current PHI2 cycle.

## Operation
- Control register bits: 0 START, 1 PBON, 2 OUTMODE, 3 RUNMODE (1 = one-shot), 4 LOAD, 6:5 INMODE, 7 channel-specific. Bits 7 and 1 are stored and read back only.
- Write: wr[i] = we & (addr == ADDR_BASE+i). next[i] = wr[i] ? data : ctrl[i].
- One-shot stop: next[i].START &= ~((ctrl[i].RUNMODE | next[i].RUNMODE) & ufl[i]). The old RUNMODE counts, so a write that clears RUNMODE in the underflow cycle still stops the timer.
- Force load: force_load[i] = next[i].LOAD & wr_prev[i], where wr_prev is wr registered at phi2_dn. If two consecutive writes occur, the LOAD bit of the second write decides.
- CNT edge: cnt_prev is registered at phi2_dn. cnt_up = cnt & ~cnt_prev.
- Count source, gated by ctrl[i].START:
  - INMODE 00: 1 (every PHI2).
  - INMODE 01: cnt_up.
  - INMODE 10: ufl[i-1].
  - INMODE 11: ufl[i-1] & cnt_prev.
  - Channel 0 has no predecessor, so INMODE 1x gives count = 0.
- start = ctrl.START. toggle = ctrl.OUTMODE.
- Readback: regs[i] = ctrl[i] with bit 4 forced to 0.

## Timing
- Reset (res_n low, asynchronous): ctrl, wr_prev and cnt_prev all go to 0. Outputs then read regs = 0, start = 0, toggle = 0, force_load = 0, count = 0.
- Release of reset is synchronous. The first update happens on the first phi2_dn after release.
- ctrl, wr_prev and cnt_prev update at clk edges where phi2_dn = 1; they hold otherwise.
- Latency from a write to start/count/toggle/regs: visible in the PHI2 cycle after the write.
- force_load is combinational: it asserts exactly one PHI2 cycle after the write and lasts that cycle only.
- count[i] for INMODE 1x is combinational from ufl[i-1] in the same cycle. Cascade depth is therefore a combinational path; NCH ≤ 8 bounds it.
- Simultaneous write of START = 1 and ufl[i] with RUNMODE = 1 (old or new): START ends 0.
- Address wrap: ADDR_BASE+i is computed modulo 16.

## Structure
- Package cia holds the following; cia::tctrl_t is reused for the per-channel output bundle:
  - the bit-position localparams;
  - cr_t, a packed struct with start, pbon, outmode, runmode, load, inmode[1:0], b7;
  - the inmode enum.
- Sub-module cia_timer_ctrl_ch holds one channel's register, wr_prev, one-shot logic and count mux. It is instantiated NCH times in a generate loop. The top level holds the address decode, the cnt_prev/cnt_up logic and the cascade wiring (ufl_prev[0] = 0).

## Test plan
- Reset: assert res_n low mid-cycle with ctrl[0] = 8'h11. Required: all outputs 0 immediately (asynchronous), before the next clk.
- Load strobe: write 8'h10 to ADDR_BASE. Required: force_load[0] = 1 for exactly the next PHI2 cycle, and regs[0] = 8'h00. Back-to-back writes 8'h10 then 8'h00: no force_load.
- One-shot: ctrl[1] = 8'h09 with ufl[1] = 1. Required: start[1] = 0 next cycle. In a separate case, write 8'h01 in the underflow cycle of a one-shot timer: start still 0.
- CNT counting: INMODE 01, START = 1, drive cnt 0→1→1→0→1. Required: count = 1 only in the two rising-edge cycles.
- Cascade, NCH = 4: ctrl[3] = 8'h61, cnt = 1, pulse ufl[2]. Required: count[3] mirrors ufl[2]. With cnt = 0: count[3] = 0. Channel 0 with INMODE 10: count[0] = 0 always.
- Address wrap: ADDR_BASE = 4'hF, NCH = 2. A write to addr 0 updates channel 1.

Source files
------------

// File: rtl/cia_timer_ctrl_n_pkg.sv
// Shared control-register layout and per-channel strobe bundle for the CIA
// timer control block.
package cia;

  localparam int CR_START   = 0;
  localparam int CR_PBON    = 1;
  localparam int CR_OUTMODE = 2;
  localparam int CR_RUNMODE = 3;
  localparam int CR_LOAD    = 4;
  localparam int CR_INMODE  = 5;
  localparam int CR_B7      = 7;

  typedef enum logic [1:0] {
    IM_PHI2    = 2'b00,
    IM_CNT     = 2'b01,
    IM_UFL     = 2'b10,
    IM_UFL_CNT = 2'b11
  } inmode_e;

  typedef struct packed {
    logic    b7;
    inmode_e inmode;
    logic    load;
    logic    runmode;
    logic    outmode;
    logic    pbon;
    logic    start;
  } cr_t;

  typedef struct packed {
    logic start;
    logic toggle;
    logic force_load;
    logic count;
  } tctrl_t;

  // LOAD is a strobe, never a persistent mode, so it always reads back as 0.
  function automatic logic [7:0] cr_readback(input cr_t c);
    logic [7:0] v;
    v = c;
    v[CR_LOAD] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/cia_timer_ctrl_n_ch.sv
// One timer channel: control register, write history, one-shot stop and
// count-source selection.
module cia_timer_ctrl_ch
  import cia::*;
(
  input  logic       clk,
  input  logic       res_n,
  input  logic       i_phi2_dn,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  input  logic       i_ufl,
  input  logic       i_ufl_pred,
  input  logic       i_cnt_up,
  input  logic       i_cnt_prev,
  output logic [7:0] o_reg,
  output tctrl_t     o_ctl
);

  cr_t  r_ctrl;
  cr_t  w_next;
  logic r_wr_prev;
  logic w_src;

  // Old or new RUNMODE stops the timer, so clearing one-shot in the
  // underflow cycle cannot keep it running.
  always_comb begin
    w_next = i_wr ? cr_t'(i_data) : r_ctrl;
    w_next.start = w_next.start & ~((r_ctrl.runmode | w_next.runmode) & i_ufl);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_ctrl    <= '0;
      r_wr_prev <= 1'b0;
    end else if (i_phi2_dn) begin
      r_ctrl    <= w_next;
      r_wr_prev <= i_wr;
    end
  end

  always_comb begin
    w_src = 1'b0;
    case (r_ctrl.inmode)
      IM_PHI2:    w_src = 1'b1;
      IM_CNT:     w_src = i_cnt_up;
      IM_UFL:     w_src = i_ufl_pred;
      IM_UFL_CNT: w_src = i_ufl_pred & i_cnt_prev;
      default:    w_src = 1'b0;
    endcase
  end

  assign o_reg            = cr_readback(r_ctrl);
  assign o_ctl.start      = r_ctrl.start;
  assign o_ctl.toggle     = r_ctrl.outmode;
  assign o_ctl.force_load = w_next.load & r_wr_prev;
  assign o_ctl.count      = r_ctrl.start & w_src;

endmodule

// File: rtl/cia_timer_ctrl_n.sv
// NCH-channel CIA timer control: address decode, CNT edge detection and
// underflow cascade around per-channel control slices.
module cia_timer_ctrl_n
  import cia::*;
#(
  parameter int         NCH       = 2,
  parameter logic [3:0] ADDR_BASE = 4'hE
)
(
  input  logic             clk,
  input  logic             res_n,
  input  logic             phi2_dn,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [7:0]       data,
  input  logic             cnt,
  input  logic [NCH-1:0]   ufl,
  output logic [NCH*8-1:0] regs,
  output logic [NCH-1:0]   start,
  output logic [NCH-1:0]   toggle,
  output logic [NCH-1:0]   force_load,
  output logic [NCH-1:0]   count
);

  logic             r_cnt_prev;
  logic             w_cnt_up;
  logic [NCH-1:0]   w_ufl_prev;
  logic [NCH-1:0]   w_wr;
  tctrl_t           w_ctl [NCH];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_cnt_prev <= 1'b0;
    end else if (phi2_dn) begin
      r_cnt_prev <= cnt;
    end
  end

  assign w_cnt_up = cnt & ~r_cnt_prev;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Four-bit sum wraps the channel address modulo 16.
    localparam logic [3:0] CH_ADDR = ADDR_BASE + 4'(i);

    assign w_wr[i] = we & (addr == CH_ADDR);

    if (i == 0) begin : g_head
      assign w_ufl_prev[i] = 1'b0;
    end else begin : g_link
      assign w_ufl_prev[i] = ufl[i-1];
    end

    cia_timer_ctrl_ch u_ch (
      .clk        (clk),
      .res_n      (res_n),
      .i_phi2_dn  (phi2_dn),
      .i_wr       (w_wr[i]),
      .i_data     (data),
      .i_ufl      (ufl[i]),
      .i_ufl_pred (w_ufl_prev[i]),
      .i_cnt_up   (w_cnt_up),
      .i_cnt_prev (r_cnt_prev),
      .o_reg      (regs[8*i +: 8]),
      .o_ctl      (w_ctl[i])
    );

    assign start[i]      = w_ctl[i].start;
    assign toggle[i]     = w_ctl[i].toggle;
    assign force_load[i] = w_ctl[i].force_load;
    assign count[i]      = w_ctl[i].count;
  end

endmodule

// File: tb/tb_cia_timer_ctrl_n.sv
// Directed bench for cia_timer_ctrl_n: a 4-channel instance at base E and a
// 2-channel instance at base F share the register bus and CNT pin.
module tb_cia_timer_ctrl_n;

  logic        clk = 1'b0;
  logic        res_n;
  logic        phi2_dn;
  logic        we;
  logic [3:0]  addr;
  logic [7:0]  data;
  logic        cnt;
  logic [3:0]  ufl_a;
  logic [1:0]  ufl_b;

  logic [31:0] regs_a;
  logic [3:0]  start_a, toggle_a, fl_a, count_a;
  logic [15:0] regs_b;
  logic [1:0]  start_b, toggle_b, fl_b, count_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cia_timer_ctrl_n #(.NCH(4), .ADDR_BASE(4'hE)) u_dut_a (
    .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .we(we), .addr(addr),
    .data(data), .cnt(cnt), .ufl(ufl_a), .regs(regs_a), .start(start_a),
    .toggle(toggle_a), .force_load(fl_a), .count(count_a)
  );

  cia_timer_ctrl_n #(.NCH(2), .ADDR_BASE(4'hF)) u_dut_b (
    .clk(clk), .res_n(res_n), .phi2_dn(phi2_dn), .we(we), .addr(addr),
    .data(data), .cnt(cnt), .ufl(ufl_b), .regs(regs_b), .start(start_b),
    .toggle(toggle_b), .force_load(fl_b), .count(count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One PHI2 cycle: a hold clock, then the phi2_dn clock.
  task automatic tick();
    @(posedge clk); #1;
    phi2_dn = 1'b1;
    @(posedge clk); #1;
    phi2_dn = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; data = d;
    tick();
    we = 1'b0;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    res_n = 1'b0; phi2_dn = 1'b0; we = 1'b0; addr = 4'h0; data = 8'h00;
    cnt = 1'b0; ufl_a = 4'h0; ufl_b = 2'b00;
    #1;
    chk("rst_regs", regs_a, 32'h0);
    chk("rst_start", {28'h0, start_a}, 32'h0);
    #1 res_n = 1'b1;

    // Async reset clears a live channel without a clock edge.
    wr(4'hE, 8'h11);
    chk("wr11_regs0", {24'h0, regs_a[7:0]}, 32'h01);
    chk("wr11_start0", {31'h0, start_a[0]}, 32'h1);
    chk("wr11_fl0", {31'h0, fl_a[0]}, 32'h1);
    chk("wr11_count0", {31'h0, count_a[0]}, 32'h1);
    #2 res_n = 1'b0;
    #1;
    chk("arst_regs", regs_a, 32'h0);
    chk("arst_start", {28'h0, start_a}, 32'h0);
    chk("arst_toggle", {28'h0, toggle_a}, 32'h0);
    chk("arst_fl", {28'h0, fl_a}, 32'h0);
    chk("arst_count", {28'h0, count_a}, 32'h0);
    res_n = 1'b1;
    tick(); #1;
    chk("post_rst_regs", regs_a, 32'h0);

    // Force-load strobe lasts exactly one PHI2 cycle.
    wr(4'hE, 8'h10);
    chk("load_fl0", {31'h0, fl_a[0]}, 32'h1);
    chk("load_regs0", {24'h0, regs_a[7:0]}, 32'h00);
    tick(); #1;
    chk("load_fl0_gone", {31'h0, fl_a[0]}, 32'h0);

    // Back-to-back: second write without LOAD suppresses the strobe.
    we = 1'b1; addr = 4'hE; data = 8'h10;
    tick();
    data = 8'h00; #1;
    chk("b2b_fl0_a", {31'h0, fl_a[0]}, 32'h0);
    tick();
    we = 1'b0; #1;
    chk("b2b_fl0_b", {31'h0, fl_a[0]}, 32'h0);

    // One-shot stop on underflow.
    wr(4'hF, 8'h09);
    chk("os_start1", {31'h0, start_a[1]}, 32'h1);
    ufl_a[1] = 1'b1; #1;
    chk("os_count1", {31'h0, count_a[1]}, 32'h1);
    tick();
    ufl_a[1] = 1'b0; #1;
    chk("os_stop1", {31'h0, start_a[1]}, 32'h0);
    chk("os_regs1", {24'h0, regs_a[15:8]}, 32'h08);

    // Clearing RUNMODE in the underflow cycle still stops the timer.
    wr(4'hF, 8'h09);
    ufl_a[1] = 1'b1;
    wr(4'hF, 8'h01);
    ufl_a[1] = 1'b0; #1;
    chk("os_clr_start1", {31'h0, start_a[1]}, 32'h0);
    chk("os_clr_regs1", {24'h0, regs_a[15:8]}, 32'h00);

    // Writing START with new RUNMODE during underflow also ends stopped.
    ufl_a[1] = 1'b1;
    wr(4'hF, 8'h09);
    ufl_a[1] = 1'b0; #1;
    chk("os_new_start1", {31'h0, start_a[1]}, 32'h0);
    chk("os_new_regs1", {24'h0, regs_a[15:8]}, 32'h08);

    // CNT rising-edge counting: cnt 0,1,1,0,1 -> count 0,1,0,0,1.
    cnt = 1'b0;
    wr(4'hE, 8'h21);
    chk("cnt_s0", {31'h0, count_a[0]}, 32'h0);
    tick();
    cnt = 1'b1; #1;
    chk("cnt_s1", {31'h0, count_a[0]}, 32'h1);
    @(posedge clk); #1;
    chk("cnt_s1_hold", {31'h0, count_a[0]}, 32'h1);
    tick(); #1;
    chk("cnt_s2", {31'h0, count_a[0]}, 32'h0);
    tick();
    cnt = 1'b0; #1;
    chk("cnt_s3", {31'h0, count_a[0]}, 32'h0);
    tick();
    cnt = 1'b1; #1;
    chk("cnt_s4", {31'h0, count_a[0]}, 32'h1);

    // Cascade into channel 3 (addr 1 after wrap).
    cnt = 1'b1;
    wr(4'h1, 8'h61);
    ufl_a[2] = 1'b1; #1;
    chk("casc_hi", {31'h0, count_a[3]}, 32'h1);
    ufl_a[2] = 1'b0; #1;
    chk("casc_lo", {31'h0, count_a[3]}, 32'h0);
    cnt = 1'b0;
    tick();
    ufl_a[2] = 1'b1; #1;
    chk("casc_nocnt", {31'h0, count_a[3]}, 32'h0);
    ufl_a[2] = 1'b0;
    wr(4'h1, 8'h41);
    ufl_a[2] = 1'b1; #1;
    chk("casc_im10", {31'h0, count_a[3]}, 32'h1);
    ufl_a[2] = 1'b0;

    // Channel 0 has no predecessor.
    wr(4'hE, 8'h41);
    ufl_a = 4'hF; #1;
    chk("ch0_im10", {31'h0, count_a[0]}, 32'h0);
    ufl_a = 4'h0;
    cnt = 1'b1;
    wr(4'hE, 8'h61);
    tick();
    ufl_a = 4'hF; #1;
    chk("ch0_im11", {31'h0, count_a[0]}, 32'h0);
    ufl_a = 4'h0;

    // OUTMODE and read-only bits.
    wr(4'hE, 8'h05);
    chk("tog_on", {31'h0, toggle_a[0]}, 32'h1);
    chk("tog_regs", {24'h0, regs_a[7:0]}, 32'h05);
    wr(4'hE, 8'h9E);
    chk("b7_regs", {24'h0, regs_a[7:0]}, 32'h8E);
    chk("b7_start", {31'h0, start_a[0]}, 32'h0);
    chk("b7_tog", {31'h0, toggle_a[0]}, 32'h1);
    chk("b7_fl", {31'h0, fl_a[0]}, 32'h1);

    // Address wrap on the base-F instance: addr 0 is channel 1.
    chk("wrap_pre", {24'h0, regs_b[15:8]}, 32'h00);
    wr(4'h0, 8'h05);
    chk("wrap_b_ch1", {24'h0, regs_b[15:8]}, 32'h05);
    chk("wrap_b_ch0", {24'h0, regs_b[7:0]}, 32'h09);
    chk("wrap_a_ch2", {24'h0, regs_a[23:16]}, 32'h05);
    chk("wrap_b_start", {30'h0, start_b}, 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
